iter_alu: RTL and testbench

ITER_ALU -- requirements
Module: iter_alu

---
 rtl/alu_pkg.sv | 35 +++
 rtl/alu_addsub.sv | 29 ++
 rtl/iter_alu.sv | 200 ++++++++++++++++++++
 tb/tb_iter_alu.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the iterative ALU.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_ADC  = 4'd1,
    OP_SUB  = 4'd2,
    OP_AND  = 4'd3,
    OP_OR   = 4'd4,
    OP_XOR  = 4'd5,
    OP_NOT  = 4'd6,
    OP_PASS = 4'd7,
    OP_SHL  = 4'd8,
    OP_SHR  = 4'd9,
    OP_ASR  = 4'd10,
    OP_MUL  = 4'd11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_e;

  // Bit positions inside the {N,V,C,Z} flags vector
  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 2;
  localparam int FLAG_N = 3;

  function automatic logic is_shift(op_e o);
    return (o == OP_SHL) || (o == OP_SHR) || (o == OP_ASR);
  endfunction

endpackage

// File: rtl/alu_addsub.sv
// Combinational adder/subtractor with carry-out and signed overflow.
// sub=1 computes x + ~y + 1, so cout=1 means "no borrow".
module alu_addsub #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  logic [WIDTH-1:0] y_eff;
  logic             c_eff;
  logic [WIDTH:0]   full;

  // Invert the second operand and force carry-in for subtraction
  always_comb begin
    y_eff = sub ? ~y : y;
    c_eff = sub | cin;
    full  = {1'b0, x} + {1'b0, y_eff} + {{WIDTH{1'b0}}, c_eff};
    sum   = full[WIDTH-1:0];
    cout  = full[WIDTH];
    ovf   = (x[WIDTH-1] == y_eff[WIDTH-1]) && (sum[WIDTH-1] != x[WIDTH-1]);
  end

endmodule

// File: rtl/iter_alu.sv
// Iterative ALU: single-cycle arithmetic/logic ops, bit-serial shifts and
// a shift-and-add multiplier behind a valid/ready command/result interface.
// Handshake: a command transfers on a rising edge with in_valid & in_ready;
// a result transfers on a rising edge with out_valid & out_ready. While a
// result waits, result/flags/out_valid hold and no new command is taken.
module iter_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);

  localparam int LOG = $clog2(WIDTH);
  localparam int CW  = LOG + 1;

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [WIDTH-1:0] wa_q, wa_d;        // shift register / multiplicand
  logic [WIDTH-1:0] mhi_q, mhi_d;      // product high half
  logic [WIDTH-1:0] mlo_q, mlo_d;      // multiplier, becomes product low half
  logic [CW-1:0]    cnt_q, cnt_d;      // remaining EXEC iterations
  logic [WIDTH-1:0] result_q, result_d;
  logic [3:0]       flags_q, flags_d;

  op_e              op_in;
  logic [LOG-1:0]   sh_n;

  logic [WIDTH-1:0] add_x, add_y, add_sum;
  logic             add_cin, add_sub, add_cout, add_ovf;

  logic [WIDTH-1:0] sh_nxt, mhi_nxt, mlo_nxt;
  logic             sh_out;

  logic [WIDTH-1:0] fin_res;
  logic             fin_c, fin_v, fin_kill, load;

  assign op_in     = op_e'(op);
  assign sh_n      = b[LOG-1:0];
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign flags     = flags_q;

  // Adder serves port operands in IDLE and the MUL accumulate in EXEC
  always_comb begin
    add_x   = a;
    add_y   = b;
    add_cin = (op_in == OP_ADC) & cin;
    add_sub = (op_in == OP_SUB);
    if (state_q == EXEC) begin
      add_x   = mhi_q;
      add_y   = mlo_q[0] ? wa_q : '0;
      add_cin = 1'b0;
      add_sub = 1'b0;
    end
  end

  alu_addsub #(.WIDTH(WIDTH)) u_addsub (
    .x    (add_x),
    .y    (add_y),
    .cin  (add_cin),
    .sub  (add_sub),
    .sum  (add_sum),
    .cout (add_cout),
    .ovf  (add_ovf)
  );

  // One iteration of the captured shift op and of the multiplier
  always_comb begin
    sh_nxt = wa_q;
    sh_out = 1'b0;
    case (op_q)
      OP_SHL: begin sh_nxt = {wa_q[WIDTH-2:0], 1'b0};        sh_out = wa_q[WIDTH-1]; end
      OP_SHR: begin sh_nxt = {1'b0, wa_q[WIDTH-1:1]};        sh_out = wa_q[0];       end
      OP_ASR: begin sh_nxt = {wa_q[WIDTH-1], wa_q[WIDTH-1:1]}; sh_out = wa_q[0];     end
      default: ;
    endcase
    mhi_nxt = {add_cout, add_sum[WIDTH-1:1]};
    mlo_nxt = {add_sum[0], mlo_q[WIDTH-1:1]};
  end

  // Next-state, datapath and result/flags load on entry to DONE
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    wa_d     = wa_q;
    mhi_d    = mhi_q;
    mlo_d    = mlo_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    flags_d  = flags_q;
    fin_res  = '0;
    fin_c    = 1'b0;
    fin_v    = 1'b0;
    fin_kill = 1'b0;
    load     = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_d  = op_in;
          wa_d  = a;
          mhi_d = '0;
          mlo_d = b;
          cnt_d = (op_in == OP_MUL) ? CW'(WIDTH) : {1'b0, sh_n};
          if (op_in == OP_MUL || (is_shift(op_in) && sh_n != '0)) begin
            state_d = EXEC;
          end else begin
            state_d = DONE;
            load    = 1'b1;
            case (op_in)
              OP_ADD, OP_ADC, OP_SUB: begin
                fin_res = add_sum;
                fin_c   = add_cout;
                fin_v   = add_ovf;
              end
              OP_AND:  fin_res = a & b;
              OP_OR:   fin_res = a | b;
              OP_XOR:  fin_res = a ^ b;
              OP_NOT:  fin_res = ~a;
              OP_PASS: fin_res = a;
              OP_SHL, OP_SHR, OP_ASR: fin_res = a;   // zero shift amount
              default: fin_kill = 1'b1;              // unused opcode
            endcase
          end
        end
      end
      EXEC: begin
        cnt_d = cnt_q - CW'(1);
        if (op_q == OP_MUL) begin
          mhi_d = mhi_nxt;
          mlo_d = mlo_nxt;
        end else begin
          wa_d = sh_nxt;
        end
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
          load    = 1'b1;
          if (op_q == OP_MUL) begin
            fin_res = mlo_nxt;
            fin_c   = |mhi_nxt;
            fin_v   = |mhi_nxt;
          end else begin
            fin_res = sh_nxt;
            fin_c   = sh_out;
          end
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      result_d = fin_res;
      flags_d  = '0;
      if (!fin_kill) begin
        flags_d[FLAG_N] = fin_res[WIDTH-1];
        flags_d[FLAG_V] = fin_v;
        flags_d[FLAG_C] = fin_c;
        flags_d[FLAG_Z] = (fin_res == '0);
      end
    end
  end

  // State and datapath registers; reset abandons any in-flight operation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      op_q     <= OP_ADD;
      wa_q     <= '0;
      mhi_q    <= '0;
      mlo_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      wa_q     <= wa_d;
      mhi_q    <= mhi_d;
      mlo_q    <= mlo_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

endmodule

// File: tb/tb_iter_alu.sv
// Directed, table-driven bench for iter_alu (WIDTH=8).
module tb_iter_alu;

  localparam int W   = 8;
  localparam int NV  = 20;
  localparam int MAXLAT = 40;

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] res;
    logic [3:0]   flg;   // {N,V,C,Z}
    int           lat;   // cycles from accept to out_valid
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   op;
  logic [W-1:0] a, b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic [3:0]   flags;

  int n_tests = 0;
  int n_fail  = 0;
  vec_t vecs[NV];

  iter_alu #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issue one command, scramble inputs while it runs, check, then consume
  task automatic run_vec(input vec_t v, input string name);
    int lat;
    op = v.op; a = v.a; b = v.b; cin = v.cin;
    in_valid = 1'b1;
    out_ready = 1'b0;
    @(posedge clk); #1;
    chk({name, "_accepted"}, {31'd0, in_ready}, 32'd0);
    lat = 1;
    while (!out_valid && lat < MAXLAT) begin
      in_valid = 1'($urandom_range(0, 1));
      op  = 4'($urandom_range(0, 15));
      a   = W'($urandom_range(0, 255));
      b   = W'($urandom_range(0, 255));
      cin = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      lat++;
    end
    chk({name, "_lat"}, lat, v.lat);
    chk({name, "_res"}, {24'd0, result}, {24'd0, v.res});
    chk({name, "_flags"}, {28'd0, flags}, {28'd0, v.flg});
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk({name, "_back_idle"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t v;
    //          op     a      b      cin   res    {NVCZ}   lat
    vecs[0]  = '{4'd2,  8'h05, 8'h07, 1'b0, 8'hFE, 4'b1000, 1};  // SUB borrow
    vecs[1]  = '{4'd0,  8'h7F, 8'h01, 1'b0, 8'h80, 4'b1100, 1};  // ADD overflow
    vecs[2]  = '{4'd1,  8'hFF, 8'h00, 1'b1, 8'h00, 4'b0011, 1};  // ADC carry
    vecs[3]  = '{4'd10, 8'h90, 8'h03, 1'b0, 8'hF2, 4'b1000, 4};  // ASR 3
    vecs[4]  = '{4'd8,  8'h81, 8'h01, 1'b0, 8'h02, 4'b0010, 2};  // SHL 1
    vecs[5]  = '{4'd11, 8'h10, 8'h11, 1'b0, 8'h10, 4'b0110, 9};  // MUL high half
    vecs[6]  = '{4'd11, 8'h03, 8'h05, 1'b0, 8'h0F, 4'b0000, 9};  // MUL small
    vecs[7]  = '{4'd3,  8'hF0, 8'h3C, 1'b1, 8'h30, 4'b0000, 1};  // AND
    vecs[8]  = '{4'd4,  8'h0F, 8'hF0, 1'b0, 8'hFF, 4'b1000, 1};  // OR
    vecs[9]  = '{4'd5,  8'hAA, 8'hAA, 1'b0, 8'h00, 4'b0001, 1};  // XOR zero
    vecs[10] = '{4'd6,  8'h0F, 8'h00, 1'b0, 8'hF0, 4'b1000, 1};  // NOT
    vecs[11] = '{4'd7,  8'h5A, 8'hFF, 1'b1, 8'h5A, 4'b0000, 1};  // PASS
    vecs[12] = '{4'd9,  8'h81, 8'h0A, 1'b0, 8'h20, 4'b0000, 3};  // SHR, n from low bits
    vecs[13] = '{4'd8,  8'h81, 8'h08, 1'b0, 8'h81, 4'b1000, 1};  // SHL n=0
    vecs[14] = '{4'd12, 8'h00, 8'h00, 1'b0, 8'h00, 4'b0000, 1};  // unused opcode
    vecs[15] = '{4'd2,  8'h07, 8'h05, 1'b0, 8'h02, 4'b0010, 1};  // SUB no borrow
    vecs[16] = '{4'd2,  8'h80, 8'h01, 1'b0, 8'h7F, 4'b0110, 1};  // SUB overflow
    vecs[17] = '{4'd10, 8'h7F, 8'h07, 1'b0, 8'h00, 4'b0011, 8};  // ASR 7, positive
    vecs[18] = '{4'd11, 8'hFF, 8'hFF, 1'b0, 8'h01, 4'b0110, 9};  // MUL max
    vecs[19] = '{4'd0,  8'hFF, 8'h01, 1'b1, 8'h00, 4'b0011, 1};  // ADD ignores cin

    // Reset
    rst_n = 1'b0; in_valid = 1'b0; op = '0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_result", {24'd0, result}, 32'd0);
    chk("rst_flags", {28'd0, flags}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Table (first vector is accepted on the first edge after release)
    for (int i = 0; i < NV; i++) begin
      run_vec(vecs[i], $sformatf("v%0d", i));
    end

    // Stall in DONE: result holds, inputs ignored
    op = 4'd0; a = 8'h7F; b = 8'h01; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      op  = 4'($urandom_range(0, 11));
      a   = W'($urandom_range(0, 255));
      b   = W'($urandom_range(0, 255));
      @(posedge clk); #1;
      chk($sformatf("stall%0d_valid", i), {31'd0, out_valid}, 32'd1);
      chk($sformatf("stall%0d_ready", i), {31'd0, in_ready}, 32'd0);
      chk($sformatf("stall%0d_res", i), {24'd0, result}, 32'h80);
      chk($sformatf("stall%0d_flags", i), {28'd0, flags}, 32'hC);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("stall_release_valid", {31'd0, out_valid}, 32'd0);
    chk("stall_release_ready", {31'd0, in_ready}, 32'd1);
    v = '{4'd7, 8'h33, 8'h00, 1'b0, 8'h33, 4'b0000, 1};
    run_vec(v, "after_stall");

    // Reset during the 4th EXEC cycle of a MUL
    op = 4'd11; a = 8'h10; b = 8'h11; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("mid_mul_busy", {31'd0, in_ready}, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("async_rst_result", {24'd0, result}, 32'd0);
    chk("async_rst_flags", {28'd0, flags}, 32'd0);
    chk("async_rst_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    chk("rst_hold_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_no_result", {31'd0, out_valid}, 32'd0);
    v = '{4'd0, 8'h03, 8'h04, 1'b0, 8'h07, 4'b0000, 1};
    run_vec(v, "after_rst");
    v = '{4'd11, 8'h06, 8'h07, 1'b0, 8'h2A, 4'b0000, 9};
    run_vec(v, "after_rst_mul");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
